// File: rtl/sim_jtag_pkg.sv
// Shared types for the JTAG bit-bang engine: command opcodes and FSM state codes.
package sim_jtag_pkg;

    typedef enum logic [1:0] {
        OP_SHIFT = 2'd0,
        OP_TRST  = 2'd1,
        OP_SRST  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOW   = 3'd1;
    localparam state_t ST_HIGH  = 3'd2;
    localparam state_t ST_PULSE = 3'd3;
    localparam state_t ST_RESP  = 3'd4;

endpackage

// File: rtl/sim_jtag_halftimer.sv
// TCK half-period timer: reloads with div on phase entry, counts only while enabled,
// and flags the edge that closes the current phase.
module sim_jtag_halftimer #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_phase_end
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_div;
        end else if (i_enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A phase therefore spans exactly div+1 enabled cycles.
    assign o_phase_end = i_enable && (r_cnt == '0);

endmodule

// File: rtl/sim_jtag_engine.sv
// JTAG bit-bang engine: accepts a whole scan or reset-pulse command, drives TCK/TMS/TDI
// (or TRST/SRST) at a programmable rate and returns the captured TDO bits.
module sim_jtag_engine
    import sim_jtag_pkg::*;
#(
    parameter int unsigned MAX_BITS     = 64,
    parameter int unsigned LEN_W        = $clog2(MAX_BITS),
    parameter int unsigned DIV_W        = 8,
    parameter logic        TDO_UNDRIVEN = 1'b0
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                enable,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DIV_W-1:0]    cmd_div,
    input  logic [MAX_BITS-1:0] cmd_tms,
    input  logic [MAX_BITS-1:0] cmd_tdi,
    input  logic                cmd_capture,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [MAX_BITS-1:0] rsp_tdo,
    output logic                rsp_undriven,
    output logic                jtag_tck,
    output logic                jtag_tms,
    output logic                jtag_tdi,
    output logic                jtag_trst_n,
    output logic                srst_n,
    input  logic                jtag_tdo_data,
    input  logic                jtag_tdo_driven,
    output logic                busy
);

    state_t              r_state;
    logic                r_tck;
    logic                r_tms;
    logic                r_tdi;
    logic                r_trst_n;
    logic                r_srst_n;
    logic                r_rsp_valid;
    logic                r_busy;
    logic                r_undrv;
    logic                r_want_rsp;
    logic [LEN_W-1:0]    r_len;
    logic [DIV_W-1:0]    r_div;
    logic [LEN_W-1:0]    r_bit_cnt;
    logic [MAX_BITS-1:0] r_tms_sr;
    logic [MAX_BITS-1:0] r_tdi_sr;
    logic [MAX_BITS-1:0] r_tdo_cap;

    logic                w_accept;
    logic                w_timed;
    logic                w_phase_end;
    logic                w_load;
    logic                w_last;
    logic                w_tdo_bit;
    logic [DIV_W-1:0]    w_load_div;
    state_t              w_end_state;

    // NOTE: cmd_ready is the one combinational output; it must drop in the same cycle
    // enable does so an offered command is never taken while the timer is frozen.
    assign cmd_ready   = (r_state == ST_IDLE) && enable;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_timed     = (r_state == ST_LOW) || (r_state == ST_HIGH) || (r_state == ST_PULSE);
    assign w_load      = w_accept || (w_timed && w_phase_end);
    assign w_load_div  = w_accept ? cmd_div : r_div;
    assign w_last      = (r_bit_cnt == r_len);
    assign w_tdo_bit   = jtag_tdo_driven ? jtag_tdo_data : TDO_UNDRIVEN;
    assign w_end_state = r_want_rsp ? ST_RESP : ST_IDLE;

    sim_jtag_halftimer #(
        .DIV_W (DIV_W)
    ) u_halftimer (
        .clk         (clk),
        .rst_l       (rst_l),
        .i_load      (w_load),
        .i_enable    (enable),
        .i_div       (w_load_div),
        .o_phase_end (w_phase_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            // NOTE: the capture register is cleared here too, because it drives rsp_tdo
            // directly and must read 0 out of reset.
            r_state     <= ST_IDLE;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_trst_n    <= 1'b1;
            r_srst_n    <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_undrv     <= 1'b0;
            r_want_rsp  <= 1'b0;
            r_len       <= '0;
            r_div       <= '0;
            r_bit_cnt   <= '0;
            r_tms_sr    <= '0;
            r_tdi_sr    <= '0;
            r_tdo_cap   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_len      <= cmd_len;
                        r_div      <= cmd_div;
                        r_want_rsp <= cmd_capture;
                        r_tdo_cap  <= '0;
                        r_undrv    <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_tck      <= 1'b0;
                        r_busy     <= 1'b1;
                        if (cmd_op == OP_TRST) begin
                            r_trst_n <= 1'b0;
                            r_state  <= ST_PULSE;
                        end else if (cmd_op == OP_SRST) begin
                            r_srst_n <= 1'b0;
                            r_state  <= ST_PULSE;
                        end else begin
                            r_tms    <= cmd_tms[0];
                            r_tdi    <= cmd_tdi[0];
                            r_tms_sr <= cmd_tms >> 1;
                            r_tdi_sr <= cmd_tdi >> 1;
                            r_state  <= ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    if (w_phase_end) begin
                        r_tck   <= 1'b1;
                        r_state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_phase_end) begin
                        r_tck                <= 1'b0;
                        r_tdo_cap[r_bit_cnt] <= w_tdo_bit;
                        if (!jtag_tdo_driven) begin
                            r_undrv <= 1'b1;
                        end
                        if (w_last) begin
                            r_state     <= w_end_state;
                            r_rsp_valid <= r_want_rsp;
                            r_busy      <= r_want_rsp;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tms     <= r_tms_sr[0];
                            r_tdi     <= r_tdi_sr[0];
                            r_tms_sr  <= r_tms_sr >> 1;
                            r_tdi_sr  <= r_tdi_sr >> 1;
                            r_state   <= ST_LOW;
                        end
                    end
                end
                ST_PULSE: begin
                    // bit_cnt doubles as the half-period counter of the reset pulse.
                    if (w_phase_end) begin
                        if (w_last) begin
                            r_trst_n    <= 1'b1;
                            r_srst_n    <= 1'b1;
                            r_state     <= w_end_state;
                            r_rsp_valid <= r_want_rsp;
                            r_busy      <= r_want_rsp;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_tdo      = r_tdo_cap;
    assign rsp_undriven = r_undrv;
    assign jtag_tck     = r_tck;
    assign jtag_tms     = r_tms;
    assign jtag_tdi     = r_tdi;
    assign jtag_trst_n  = r_trst_n;
    assign srst_n       = r_srst_n;
    assign busy         = r_busy;

endmodule

// File: tb/tb_sim_jtag_engine.sv
// Self-checking bench for sim_jtag_engine: a phase-list reference model checked every cycle,
// directed scenarios pinned with hand-computed values, then randomized command traffic.
`timescale 1ns/1ps
module tb_sim_jtag_engine;

    localparam int MAX_BITS = 64;
    localparam int LEN_W    = 6;
    localparam int DIV_W    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_l;
    logic                enable;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [LEN_W-1:0]    cmd_len;
    logic [DIV_W-1:0]    cmd_div;
    logic [MAX_BITS-1:0] cmd_tms;
    logic [MAX_BITS-1:0] cmd_tdi;
    logic                cmd_capture;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [MAX_BITS-1:0] rsp_tdo;
    logic                rsp_undriven;
    logic                jtag_tck;
    logic                jtag_tms;
    logic                jtag_tdi;
    logic                jtag_trst_n;
    logic                srst_n;
    logic                busy;

    logic tdo_loop;
    logic tdo_rand;
    logic tdo_drv_rand;
    logic rnd_mode;
    wire  jtag_tdo_data   = tdo_loop ? jtag_tdi : tdo_rand;
    wire  jtag_tdo_driven = tdo_loop ? 1'b1 : tdo_drv_rand;

    sim_jtag_engine dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .enable          (enable),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_len         (cmd_len),
        .cmd_div         (cmd_div),
        .cmd_tms         (cmd_tms),
        .cmd_tdi         (cmd_tdi),
        .cmd_capture     (cmd_capture),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_tdo         (rsp_tdo),
        .rsp_undriven    (rsp_undriven),
        .jtag_tck        (jtag_tck),
        .jtag_tms        (jtag_tms),
        .jtag_tdi        (jtag_tdi),
        .jtag_trst_n     (jtag_trst_n),
        .srst_n          (srst_n),
        .jtag_tdo_data   (jtag_tdo_data),
        .jtag_tdo_driven (jtag_tdo_driven),
        .busy            (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a command becomes a list of pin-level phases, each lasting a number
    // of enabled cycles; outputs follow the head phase until the list runs dry.
    typedef struct {
        logic tck;
        logic tms;
        logic tdi;
        logic trst_n;
        logic srst_n;
        bit   sample;
        int   bitn;
        int   dur;
    } phase_t;

    phase_t      mq[$];
    int          m_rem;
    bit          m_armed = 0;
    bit          m_run   = 0;
    bit          m_resp  = 0;
    bit          m_cap   = 0;
    logic [63:0] m_acc;
    logic        m_undrv;
    logic        e_tck, e_tms, e_tdi, e_trst, e_srst, e_rsp_valid, e_rsp_undrv;
    logic [63:0] e_rsp_tdo;

    function automatic phase_t mk(input logic tck, input logic tms, input logic tdi,
                                  input logic trst, input logic srst, input bit smp,
                                  input int bitn, input int dur);
        phase_t p;
        p.tck = tck; p.tms = tms; p.tdi = tdi; p.trst_n = trst; p.srst_n = srst;
        p.sample = smp; p.bitn = bitn; p.dur = dur;
        return p;
    endfunction

    always @(posedge clk) begin
        if (!rst_l) begin
            m_armed = 1; m_run = 0; m_resp = 0; mq.delete();
            e_tck = 0; e_tms = 1; e_tdi = 0; e_trst = 1; e_srst = 1;
            e_rsp_valid = 0; e_rsp_tdo = '0; e_rsp_undrv = 0;
        end else if (m_armed && m_resp) begin
            if (rsp_ready) begin
                m_resp = 0; e_rsp_valid = 0;
            end
        end else if (m_armed && m_run) begin
            if (enable) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (mq[0].sample) begin
                        m_acc[mq[0].bitn] = jtag_tdo_driven ? jtag_tdo_data : 1'b0;
                        if (!jtag_tdo_driven) m_undrv = 1;
                    end
                    void'(mq.pop_front());
                    if (mq.size() == 0) begin
                        m_run = 0; e_tck = 0; e_trst = 1; e_srst = 1;
                        if (m_cap) begin
                            m_resp = 1; e_rsp_valid = 1; e_rsp_tdo = m_acc; e_rsp_undrv = m_undrv;
                        end
                    end else begin
                        e_tck = mq[0].tck; e_tms = mq[0].tms; e_tdi = mq[0].tdi;
                        e_trst = mq[0].trst_n; e_srst = mq[0].srst_n; m_rem = mq[0].dur;
                    end
                end
            end
        end else if (m_armed && cmd_valid && enable) begin
            if (cmd_op == 2'd1 || cmd_op == 2'd2) begin
                mq.push_back(mk(1'b0, e_tms, e_tdi, cmd_op != 2'd1, cmd_op != 2'd2, 0, 0,
                                (int'(cmd_len) + 1) * (int'(cmd_div) + 1)));
            end else begin
                for (int i = 0; i <= int'(cmd_len); i++) begin
                    mq.push_back(mk(1'b0, cmd_tms[i], cmd_tdi[i], 1'b1, 1'b1, 0, i, int'(cmd_div) + 1));
                    mq.push_back(mk(1'b1, cmd_tms[i], cmd_tdi[i], 1'b1, 1'b1, 1, i, int'(cmd_div) + 1));
                end
            end
            m_acc = '0; m_undrv = 0; m_cap = cmd_capture; m_run = 1;
            e_tck = mq[0].tck; e_tms = mq[0].tms; e_tdi = mq[0].tdi;
            e_trst = mq[0].trst_n; e_srst = mq[0].srst_n; m_rem = mq[0].dur;
        end
    end

    // Per-cycle comparison plus free-running activity counters used by the directed tests.
    int          n_busy = 0, n_rise = 0, n_hi = 0, n_trst = 0, n_srst = 0, n_hs = 0;
    logic        prev_tck = 1'b0;
    logic [63:0] last_tdo = '0;
    logic        last_undrv = 1'b0;

    always @(negedge clk) begin
        if (m_armed) begin
            check("jtag_tck", jtag_tck, e_tck);
            check("jtag_tms", jtag_tms, e_tms);
            check("jtag_tdi", jtag_tdi, e_tdi);
            check("jtag_trst_n", jtag_trst_n, e_trst);
            check("srst_n", srst_n, e_srst);
            check("rsp_valid", rsp_valid, e_rsp_valid);
            check("busy", busy, m_run || m_resp);
            check("cmd_ready", cmd_ready, !m_run && !m_resp && enable);
            if (e_rsp_valid) begin
                check("rsp_tdo", rsp_tdo, e_rsp_tdo);
                check("rsp_undriven", rsp_undriven, e_rsp_undrv);
            end
            if (busy && !rsp_valid) n_busy++;
            if (jtag_tck) n_hi++;
            if (jtag_tck && !prev_tck) n_rise++;
            if (!jtag_trst_n) n_trst++;
            if (!srst_n) n_srst++;
            if (rsp_valid && rsp_ready) begin
                n_hs++; last_tdo = rsp_tdo; last_undrv = rsp_undriven;
            end
            prev_tck = jtag_tck;
        end
    end

    int s_busy, s_rise, s_hi, s_trst, s_srst, s_hs;

    task automatic snap();
        s_busy = n_busy; s_rise = n_rise; s_hi = n_hi;
        s_trst = n_trst; s_srst = n_srst; s_hs = n_hs;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            enable       = ($urandom_range(7) != 0);
            rsp_ready    = $urandom_range(1);
            tdo_rand     = $urandom_range(1);
            tdo_drv_rand = ($urandom_range(5) != 0);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input int len, input int div,
                            input logic [63:0] tms, input logic [63:0] tdi, input logic cap);
        bit acc = 0;
        cmd_valid = 1; cmd_op = op; cmd_len = len[LEN_W-1:0]; cmd_div = div[DIV_W-1:0];
        cmd_tms = tms; cmd_tdi = tdi; cmd_capture = cap;
        for (int i = 0; i < 3000 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            step();
        end
        cmd_valid = 0;
        check("accept_in_time", acc, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) done = 1;
            step();
        end
        check("idle_in_time", done, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]  op;
        int          len, div, r;
        logic [63:0] tv, dv;
        bit          seen;

        rst_l = 0; enable = 1; cmd_valid = 0; cmd_op = 0; cmd_len = 0; cmd_div = 0;
        cmd_tms = 0; cmd_tdi = 0; cmd_capture = 0; rsp_ready = 1;
        tdo_loop = 1; tdo_rand = 0; tdo_drv_rand = 1; rnd_mode = 0;
        repeat (3) step();
        rst_l = 1;

        // Reset state.
        @(negedge clk);
        check("reset_tms", jtag_tms, 1);
        check("reset_tck", jtag_tck, 0);
        check("reset_trst_n", jtag_trst_n, 1);
        check("reset_srst_n", srst_n, 1);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_tdo", rsp_tdo, 64'h0);
        check("reset_busy", busy, 0);
        step();

        // 5-bit loopback shift, div=1.
        snap();
        send_cmd(2'd0, 4, 1, 64'b00110, 64'b10101, 1);
        wait_idle(200);
        check("t1_shift_cycles", n_busy - s_busy, 20);
        check("t1_tck_pulses", n_rise - s_rise, 5);
        check("t1_tck_high_cycles", n_hi - s_hi, 10);
        check("t1_responses", n_hs - s_hs, 1);
        check("t1_rsp_tdo", last_tdo, 64'h15);
        check("t1_rsp_undriven", last_undrv, 0);

        // Full-width shift at clk/2 with TDO undriven.
        tdo_loop = 0; tdo_rand = 1; tdo_drv_rand = 0;
        snap();
        send_cmd(2'd0, 63, 0, {$urandom, $urandom}, {$urandom, $urandom}, 1);
        wait_idle(400);
        check("t2_tck_pulses", n_rise - s_rise, 64);
        check("t2_shift_cycles", n_busy - s_busy, 128);
        check("t2_rsp_tdo", last_tdo, 64'h0);
        check("t2_rsp_undriven", last_undrv, 1);
        tdo_loop = 1; tdo_drv_rand = 1;

        // TRST pulse then a minimal SRST pulse.
        snap();
        send_cmd(2'd1, 9, 2, 64'h0, 64'h0, 1);
        wait_idle(200);
        check("t3_trst_low_cycles", n_trst - s_trst, 30);
        check("t3_tck_high_cycles", n_hi - s_hi, 0);
        check("t3_responses", n_hs - s_hs, 1);
        check("t3_rsp_tdo", last_tdo, 64'h0);
        snap();
        send_cmd(2'd2, 0, 0, 64'h0, 64'h0, 0);
        wait_idle(50);
        check("t3_srst_low_cycles", n_srst - s_srst, 1);
        check("t3_no_response", n_hs - s_hs, 0);

        // enable dropped for 7 cycles inside the first HIGH phase of a div=3 shift.
        snap();
        send_cmd(2'd0, 3, 3, 64'h0, 64'hB, 1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = jtag_tck;
        end
        check("t4_tck_rose", seen, 1);
        step();
        enable = 0;
        repeat (7) step();
        enable = 1;
        wait_idle(200);
        check("t4_tck_high_cycles", n_hi - s_hi, 23);
        check("t4_shift_cycles", n_busy - s_busy, 39);
        check("t4_rsp_tdo", last_tdo, 64'hB);

        // Response back-pressure, then reset in the middle of a shift.
        rsp_ready = 0;
        send_cmd(2'd0, 7, 0, 64'h0, 64'hA5, 1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        check("t5_rsp_valid_seen", seen, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_hold_rsp_valid", rsp_valid, 1);
            check("t5_hold_rsp_tdo", rsp_tdo, 64'hA5);
            check("t5_hold_cmd_ready", cmd_ready, 0);
        end
        step();
        rsp_ready = 1;
        wait_idle(20);
        send_cmd(2'd0, 20, 2, {$urandom, $urandom}, {$urandom, $urandom}, 1);
        repeat (15) step();
        rst_l = 0;
        step();
        rst_l = 1;
        @(negedge clk);
        check("t5_rst_tck", jtag_tck, 0);
        check("t5_rst_tms", jtag_tms, 1);
        check("t5_rst_tdi", jtag_tdi, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rsp_valid", rsp_valid, 0);
        check("t5_rst_cmd_ready", cmd_ready, 1);
        snap();
        repeat (100) step();
        check("t5_no_response_after_reset", n_hs - s_hs, 0);

        // Randomized traffic, back-to-back, with enable/rsp_ready/TDO jitter.
        tdo_loop = 0;
        rnd_mode = 1;
        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(9);
            op = (r < 7) ? 2'd0 : (r == 7) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
            len = ($urandom_range(3) == 0) ? $urandom_range(63) : $urandom_range(15);
            div = $urandom_range(3);
            tv  = {$urandom, $urandom};
            dv  = {$urandom, $urandom};
            send_cmd(op, len, div, tv, dv, 1'($urandom_range(1)));
        end
        wait_idle(5000);
        rnd_mode = 0;
        enable = 1;
        rsp_ready = 1;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
